// File: rtl/obstacle_stream.sv
// obstacle_stream: scrolling ring buffer of upcoming track rows (three lanes
// each) feeding the game logic stage. On each accepted new_frame the block
// advances its progress counter and, when a half block completes, retires
// the nearest row and appends a pseudo-random one. It then streams every
// lane cell as a 16-bit obstacle word.
// Optional build macro: OBSTACLE_PASSABLE_EN forces one empty lane into any
// generated row that would otherwise be fully blocked.
module obstacle_stream #(
  parameter int          NUM_ROWS          = 8,
  parameter int          HALF_BLOCK_LENGTH = 64,
  parameter int          SPEED             = 4,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame,
  input  logic        game_over,
  output logic [15:0] obstacle,
  output logic        obstacle_valid,
  output logic        firstrow,
  output logic        busy,
  output logic        overrun
);

  localparam int            PW         = $clog2(HALF_BLOCK_LENGTH);
  localparam logic [PW-1:0] PROG_LIMIT = PW'(HALF_BLOCK_LENGTH - SPEED);
  localparam logic [PW-1:0] PROG_STEP  = PW'(SPEED);
  localparam logic [2:0]    LAST_ROW   = 3'(NUM_ROWS - 1);
  localparam logic [3:0]    ROWS_W     = 4'(NUM_ROWS);
  localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADVANCE,
    S_GENERATE,
    S_STREAM
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    rows_q [NUM_ROWS];
  logic [8:0]    rows_d [NUM_ROWS];
  logic [2:0]    head_q, head_d;
  logic [PW-1:0] progress_q, progress_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [2:0]    srow_q, srow_d;
  logic [1:0]    slane_q, slane_d;
  logic [15:0]   obstacle_q, obstacle_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;

  logic [8:0]    gen_row;
  logic [3:0]    addr_sum;
  logic [2:0]    addr;
  logic [8:0]    sel_row;
  logic [2:0]    sel_type;

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: each comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (new_frame) state_d = S_ADVANCE;
      S_ADVANCE:  state_d = (game_over || progress_q < PROG_LIMIT) ? S_STREAM : S_GENERATE;
      S_GENERATE: state_d = S_STREAM;
      S_STREAM:   if (srow_q == LAST_ROW && slane_q == 2'd2) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Candidate tail row from the current LFSR value
  always_comb begin
    gen_row = '0;
    for (int l = 0; l < 3; l++) begin
      // Raw codes 101..111 (ramps, moving cars) are never generated.
      gen_row[3*l +: 3] = (lfsr_q[3*l +: 3] > 3'd4) ? 3'd0 : lfsr_q[3*l +: 3];
    end
`ifdef OBSTACLE_PASSABLE_EN
    if (gen_row[2:0] != 3'd0 && gen_row[5:3] != 3'd0 && gen_row[8:6] != 3'd0) begin
      case (lfsr_q[10:9])
        2'd1:    gen_row[5:3] = 3'd0;
        2'd2:    gen_row[8:6] = 3'd0;
        default: gen_row[2:0] = 3'd0;  // codes 0 and 3 both reduce to lane 0
      endcase
    end
`endif
  end

  // Datapath next values: LFSR, progress, ring buffer, stream position, overrun
  always_comb begin
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    progress_d = progress_q;
    rows_d     = rows_q;
    head_d     = head_q;
    overrun_d  = overrun_q | (new_frame && state_q != S_IDLE);
    srow_d     = 3'd0;
    slane_d    = 2'd0;

    if (state_q == S_ADVANCE && !game_over) begin
      progress_d = (progress_q < PROG_LIMIT) ? progress_q + PROG_STEP : '0;
    end

    if (state_q == S_GENERATE) begin
      // The retired head slot is reused as the new farthest row.
      rows_d[head_q] = gen_row;
      head_d         = (head_q == LAST_ROW) ? 3'd0 : head_q + 3'd1;
    end

    if (state_q == S_STREAM) begin
      if (slane_q == 2'd2) begin
        slane_d = 2'd0;
        srow_d  = srow_q + 3'd1;
      end else begin
        slane_d = slane_q + 2'd1;
        srow_d  = srow_q;
      end
    end
  end

  // Registered output values for the word shown next cycle
  always_comb begin
    addr_sum = {1'b0, head_d} + {1'b0, srow_d};
    if (addr_sum >= ROWS_W) addr_sum = addr_sum - ROWS_W;
    addr    = addr_sum[2:0];
    sel_row = rows_d[addr];
    case (slane_d)
      2'd0:    sel_type = sel_row[2:0];
      2'd1:    sel_type = sel_row[5:3];
      default: sel_type = sel_row[8:6];
    endcase

    obstacle_d = 16'h0000;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    busy_d     = (state_d != S_IDLE);
    if (state_d == S_STREAM) begin
      obstacle_d = {sel_type, slane_d, srow_d, 8'h00};
      valid_d    = 1'b1;
      first_d    = (srow_d == 3'd0);
    end
  end

  // Row storage, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the row buffer is reset because play must start on an empty track; it is small flop storage.
      for (int r = 0; r < NUM_ROWS; r++) rows_q[r] <= '0;
      head_q     <= '0;
      progress_q <= '0;
      lfsr_q     <= LFSR_SEED;
      srow_q     <= '0;
      slane_q    <= '0;
      obstacle_q <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rows_q     <= rows_d;
      head_q     <= head_d;
      progress_q <= progress_d;
      lfsr_q     <= lfsr_d;
      srow_q     <= srow_d;
      slane_q    <= slane_d;
      obstacle_q <= obstacle_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign obstacle       = obstacle_q;
  assign obstacle_valid = valid_q;
  assign firstrow       = first_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_obstacle_stream.sv
// Testbench for obstacle_stream: drives frames and compares every streamed
// word against a queue-based model of the track rows.
module tb_obstacle_stream;

  localparam int          NUM_ROWS        = 8;
  localparam int          HBL             = 64;
  localparam int          SPEED           = 4;
  localparam int          WORDS           = 3 * NUM_ROWS;
  localparam int          FRAMES_PER_WRAP = HBL / SPEED;
  localparam logic [15:0] SEED            = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic        game_over = 1'b0;
  logic [15:0] obstacle;
  logic        obstacle_valid;
  logic        firstrow;
  logic        busy;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  obstacle_stream #(
    .NUM_ROWS(NUM_ROWS),
    .HALF_BLOCK_LENGTH(HBL),
    .SPEED(SPEED),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .new_frame(new_frame),
    .game_over(game_over),
    .obstacle(obstacle),
    .obstacle_valid(obstacle_valid),
    .firstrow(firstrow),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: rows by distance from the player (front = nearest)
  logic [8:0]  m_rows[$];
  logic [15:0] m_lfsr;
  int          m_frames;
  bit          m_overrun;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [8:0] gen_row(input logic [15:0] v);
    logic [2:0] t [3];
    for (int l = 0; l < 3; l++) begin
      t[l] = v[3*l +: 3];
      if (t[l] >= 3'd5) t[l] = 3'd0;
    end
`ifdef OBSTACLE_PASSABLE_EN
    if (t[0] != 3'd0 && t[1] != 3'd0 && t[2] != 3'd0) t[int'(v[10:9]) % 3] = 3'd0;
`endif
    return {t[2], t[1], t[0]};
  endfunction

  task automatic model_reset();
    m_rows.delete();
    for (int r = 0; r < NUM_ROWS; r++) m_rows.push_back(9'h000);
    m_frames  = 0;
    m_overrun = 1'b0;
  endtask

  // Runs one frame starting at the current negedge (cycle T). extra_pulse:
  // cycle offset for a second new_frame (-1 none, -2 last word cycle).
  // abort_word: word index on which rst is asserted (-1 none).
  task automatic run_frame(input string name, input bit go, input int extra_pulse,
                           input int abort_word, output int first_cycle, output int nwords);
    bit          wrap;
    bit          ovr_start;
    bit          exp_ovr;
    int          fv;
    int          ep;
    int          k;
    logic [8:0]  row_v;
    logic [15:0] exp_word;
    first_cycle = -1;
    nwords      = 0;
    ovr_start   = m_overrun;
    game_over   = go;
    new_frame   = 1'b1;
    wrap        = 1'b0;
    if (!go) begin
      m_frames++;
      wrap = (m_frames % FRAMES_PER_WRAP) == 0;
    end
    fv = wrap ? 3 : 2;
    ep = (extra_pulse == -2) ? fv + WORDS - 1 : extra_pulse;
    for (int c = 1; c <= fv + WORDS; c++) begin
      @(negedge clk);
      new_frame = (c == ep);
      if (wrap && c == 2) begin
        void'(m_rows.pop_front());
        m_rows.push_back(gen_row(m_lfsr));
      end
      if (obstacle_valid === 1'b1) begin
        if (first_cycle < 0) first_cycle = c;
        nwords++;
      end
      exp_ovr = ovr_start || (ep > 0 && c > ep);
      tests++;
      if (overrun !== exp_ovr) begin
        fails++;
        $display("FAIL %s overrun: T+%0d got %b want %b", name, c, overrun, exp_ovr);
      end
      if (c < fv) begin
        tests++;
        if (obstacle_valid !== 1'b0 || obstacle !== 16'h0000 || busy !== 1'b1) begin
          fails++;
          $display("FAIL %s pre_stream: T+%0d got valid=%b obstacle=%h busy=%b want valid=0 obstacle=0000 busy=1",
                   name, c, obstacle_valid, obstacle, busy);
        end
      end else if (c < fv + WORDS) begin
        k        = c - fv;
        row_v    = m_rows[k / 3];
        exp_word = {row_v[3*(k%3) +: 3], 2'(k % 3), 3'(k / 3), 8'h00};
        tests++;
        if (obstacle_valid !== 1'b1 || obstacle !== exp_word || firstrow !== (k < 3) || busy !== 1'b1) begin
          fails++;
          $display("FAIL %s word%0d: T+%0d got valid=%b obstacle=%h firstrow=%b busy=%b want valid=1 obstacle=%h firstrow=%b busy=1",
                   name, k, c, obstacle_valid, obstacle, firstrow, busy, exp_word, (k < 3));
        end
        if (k == abort_word) begin
          rst = 1'b1;
          @(negedge clk);
          rst       = 1'b0;
          new_frame = 1'b0;
          tests++;
          if (obstacle_valid !== 1'b0 || busy !== 1'b0 || obstacle !== 16'h0000 ||
              firstrow !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL %s after_rst: got valid=%b busy=%b obstacle=%h firstrow=%b overrun=%b want all zero",
                     name, obstacle_valid, busy, obstacle, firstrow, overrun);
          end
          model_reset();
          game_over = 1'b0;
          return;
        end
      end else begin
        tests++;
        if (obstacle_valid !== 1'b0 || busy !== 1'b0 || obstacle !== 16'h0000 || firstrow !== 1'b0) begin
          fails++;
          $display("FAIL %s post_stream: T+%0d got valid=%b busy=%b obstacle=%h firstrow=%b want all zero",
                   name, c, obstacle_valid, busy, obstacle, firstrow);
        end
      end
    end
    if (ep > 0) m_overrun = 1'b1;
    game_over = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    new_frame = 1'b0;
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (obstacle !== 16'h0000 || obstacle_valid !== 1'b0 || firstrow !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got obstacle=%h valid=%b firstrow=%b busy=%b overrun=%b want all zero",
               obstacle, obstacle_valid, firstrow, busy, overrun);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    tests++;
    if (obstacle_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got valid=%b busy=%b overrun=%b want 0 0 0", obstacle_valid, busy, overrun);
    end
  endtask

  task automatic test_first_frame();
    int fc, nw;
    run_frame("first_frame", 1'b0, -1, -1, fc, nw);
    tests++;
    if (fc !== 2 || nw !== WORDS) begin
      fails++;
      $display("FAIL first_frame timing: got first=T+%0d words=%0d want first=T+2 words=%0d", fc, nw, WORDS);
    end
  endtask

  // Frames 2..16 after reset; the 16th completes the half block.
  task automatic test_wrap();
    int fc, nw, want;
    for (int i = 2; i <= FRAMES_PER_WRAP; i++) begin
      run_frame("wrap", 1'b0, -1, -1, fc, nw);
      want = (i == FRAMES_PER_WRAP) ? 3 : 2;
      tests++;
      if (fc !== want || nw !== WORDS) begin
        fails++;
        $display("FAIL wrap frame%0d: got first=T+%0d words=%0d want first=T+%0d words=%0d", i, fc, nw, want, WORDS);
      end
    end
  endtask

  task automatic test_random();
    int fc, nw;
    for (int i = 0; i < 512; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame("random", ($urandom_range(0, 3) == 0), -1, -1, fc, nw);
      tests++;
      if (nw !== WORDS) begin
        fails++;
        $display("FAIL random frame%0d: got words=%0d want %0d", i, nw, WORDS);
      end
    end
  endtask

  task automatic test_game_over();
    int fc, nw;
    for (int i = 0; i < 20; i++) begin
      run_frame("game_over", 1'b1, -1, -1, fc, nw);
      tests++;
      if (fc !== 2 || nw !== WORDS) begin
        fails++;
        $display("FAIL game_over frame%0d: got first=T+%0d words=%0d want first=T+2 words=%0d", i, fc, nw, WORDS);
      end
    end
  endtask

  task automatic test_overrun();
    int fc, nw;
    run_frame("overrun", 1'b0, 5, -1, fc, nw);
    tests++;
    if (nw !== WORDS) begin
      fails++;
      $display("FAIL overrun words: got %0d want %0d", nw, WORDS);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (obstacle_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun idle: got valid=%b busy=%b overrun=%b want 0 0 1", obstacle_valid, busy, overrun);
    end
    run_frame("overrun_sticky", 1'b0, -1, -1, fc, nw);
  endtask

  task automatic test_idle_return();
    int fc, nw;
    run_frame("idle_return_drop", 1'b0, -2, -1, fc, nw);
    run_frame("idle_return_accept", 1'b0, -1, -1, fc, nw);
    tests++;
    if (nw !== WORDS) begin
      fails++;
      $display("FAIL idle_return accept: got words=%0d want %0d", nw, WORDS);
    end
  endtask

  task automatic test_reset_mid_stream();
    int fc, nw;
    run_frame("mid_rst", 1'b0, -1, 9, fc, nw);
    tests++;
    if (nw !== 10) begin
      fails++;
      $display("FAIL mid_rst words: got %0d want 10", nw);
    end
    run_frame("after_rst", 1'b0, -1, -1, fc, nw);
    tests++;
    if (fc !== 2 || nw !== WORDS) begin
      fails++;
      $display("FAIL after_rst timing: got first=T+%0d words=%0d want first=T+2 words=%0d", fc, nw, WORDS);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_wrap();
    test_random();
    test_game_over();
    test_overrun();
    test_idle_return();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/obstacle_stream.md
# obstacle_stream

Upstream feeder for the game logic stage. Holds a scrolling ring buffer of upcoming track rows (three lanes each) and generates new rows pseudo-randomly as the player advances. On every `new_frame` it streams each lane cell to the game logic stage as a 16-bit obstacle word with `obstacle_valid` and `firstrow` flags. Block-progress bookkeeping matches the game logic stage exactly, so row retirement lines up with that stage's half-block wrap.

## Interface
- `NUM_ROWS`, 8: rows held in the buffer; row 0 is nearest the player; legal range 2..8.
- `HALF_BLOCK_LENGTH`, 64: score points per row; must equal the game logic value.
- `SPEED`, 4: score points per frame; must equal the game logic value and divide `HALF_BLOCK_LENGTH`.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `new_frame` in 1: single-cycle frame strobe.
- `game_over` in 1: from game logic; freezes scrolling.
- `obstacle` out 16: obstacle word.
  - [15:13] type: 000 empty, 001 low barrier, 010 high barrier, 011 middle barrier, 100 train car.
  - [12:11] lane, 0..2.
  - [10:8] row offset.
  - [7:0] zero.
- `obstacle_valid` out 1: `obstacle` is valid this cycle.
- `firstrow` out 1: high with valid words whose row offset is 0.
- `busy` out 1: frame processing in progress.
- `overrun` out 1: sticky; set when a `new_frame` is dropped; cleared only by `rst`.

## Operation
- Storage: `NUM_ROWS` × 9 bits, three 3-bit lane types per row, organised as a ring with a head pointer (row offset 0).
- Progress counter: `$clog2(HALF_BLOCK_LENGTH)` bits.
- LFSR: 16-bit Galois, taps 16'hB400; steps every clock while not in reset.
- FSM states: IDLE, ADVANCE, GENERATE, STREAM.
  - IDLE → ADVANCE: on `new_frame`.
  - ADVANCE, `game_over`=1: progress unchanged; go to STREAM.
  - ADVANCE, progress < `HALF_BLOCK_LENGTH`-`SPEED`: progress += `SPEED`; go to STREAM.
  - ADVANCE, otherwise: progress ← 0; go to GENERATE.
  - GENERATE: retire the head row; head pointer advances modulo `NUM_ROWS`; the freed slot becomes the new tail (offset `NUM_ROWS`-1) with generated contents; go to STREAM.
  - STREAM: emits 3×`NUM_ROWS` words, one per cycle, in order row 0 lane 0, lane 1, lane 2, row 1 lane 0, and so on; then returns to IDLE.
- Row generation, lane l: raw type = LFSR[3l+2:3l].
  - Raw values 101, 110, 111 map to 000; ramps and moving cars are not generated.
  - Other raw values pass through unchanged.
- `new_frame` seen in any state other than IDLE is dropped and sets `overrun`.
- Arithmetic is unsigned. The row offset field is the head-relative index, not the storage address.

## Timing
- Reset values:
  - All rows 000; head 0; progress 0; LFSR = `LFSR_SEED`; state IDLE.
  - `obstacle`=0, `obstacle_valid`=0, `firstrow`=0, `busy`=0, `overrun`=0.
- Latency, with `new_frame` sampled at cycle T:
  - `busy`=1 from T+1 until the last valid word.
  - First `obstacle_valid` at T+2 without a wrap, T+3 with a wrap (GENERATE inserted).
  - Valid words are contiguous for 3×`NUM_ROWS` cycles; `busy` drops the cycle after the last word.
- All outputs are registered. `obstacle`=0 whenever `obstacle_valid`=0.
- A `new_frame` arriving in the same cycle the FSM returns to IDLE is dropped. The next one arriving with the FSM in IDLE is accepted.
- Reset mid-stream: the next cycle shows all outputs at reset values. The partial stream is abandoned with no trailing valid words.
- Progress alignment: after a common reset, the wrap occurs on the same frame as the game logic's half-block wrap, every `HALF_BLOCK_LENGTH`/`SPEED` frames.

## Configuration
- `OBSTACLE_PASSABLE_EN` defined: in GENERATE, if no lane maps to 000, force lane (LFSR[10:9] mod 3) to 000. Every generated row then has at least one empty lane.
- Not defined: lane types are the raw mapping only; rows may be fully blocked.

## Test plan
- Reset, then one `new_frame` with `game_over`=0:
  - 24 words appear starting at T+2, all type 000.
  - Row offsets run 0..7, lanes 0,1,2 per row.
  - `firstrow`=1 on the first 3 words only; `busy` falls at T+26.
- 16 frames (64/4):
  - Frames 1–15 start streaming at T+2; frame 16 starts at T+3.
  - After frame 16, the previous offset-1 row appears at offset 0.
  - The new offset-7 row matches the reference-model LFSR mapping for the GENERATE cycle.
- `game_over`=1 held across 20 frames: each frame streams 24 words, no row ever retires, and contents stay identical.
- `new_frame` pulsed at T and again at T+5: only one stream of 24 words occurs, `overrun`=1 from T+6, and it stays set until `rst`.
- With `OBSTACLE_PASSABLE_EN`, 1000 wraps: every generated row has at least one lane of 000 and never contains a type ≥101. Without it, each row equals the raw mapping.
- `rst` asserted on the 10th streamed word: the next cycle shows `obstacle_valid`=0 and `busy`=0; the next frame streams all-000 rows starting at T+2.
